// File: rtl/i2c_target_regfile_if.sv
// I2C pad-side bundle for the register-file target: raw SCL/SDA inputs and the
// open-drain SDA pull-down enable.
interface i2c_target_regfile_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, emulating the HDMI transmitter's
// configuration space. SCL/SDA are oversampled in clk_100m, SDA is driven
// open-drain (no clock stretching). The local fabric gets a registered read
// port and a per-byte write-event stream.
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR = 7'h39,
    parameter int unsigned REG_AW   = 8,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned HOLD_CYC = 30
) (
    input  logic                  clk_100m,
    input  logic                  reset_n,
    i2c_target_regfile_if.slave   bus,
    input  logic [REG_AW-1:0]     loc_addr,
    output logic [7:0]            loc_rdata,
    output logic                  wr_evt,
    output logic [REG_AW-1:0]     wr_evt_addr,
    output logic [7:0]            wr_evt_data,
    output logic                  busy
);
    localparam int unsigned NREGS = 2**REG_AW;
    localparam int unsigned FW    = $clog2(FILT_LEN + 1);
    localparam int unsigned HW    = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
    } state_t;

    state_t            state;
    logic              scl_s1, scl_s2, sda_s1, sda_s2;
    logic              scl_f, sda_f, scl_fd, sda_fd;
    logic [FW-1:0]     scl_cnt, sda_cnt;
    logic [HW-1:0]     hold_cnt;
    logic [7:0]        shreg;
    logic [3:0]        bit_cnt;
    logic              nine;
    logic [REG_AW-1:0] ptr;
    logic [7:0]        regs [NREGS];

    logic              scl_rise, scl_fall, start_det, stop_det, hold_done;
    logic [7:0]        byte_in;
    logic [REG_AW-1:0] ptr_nxt;

    // Two-flop synchronisers followed by a stability filter on each line
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1  <= 1'b1;
            scl_s2  <= 1'b1;
            sda_s1  <= 1'b1;
            sda_s2  <= 1'b1;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_fd  <= 1'b1;
            sda_fd  <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_s1 <= bus.scl_i;
            scl_s2 <= scl_s1;
            sda_s1 <= bus.sda_i;
            sda_s2 <= sda_s1;
            if (scl_s2 != scl_f) begin
                if (scl_cnt == FW'(FILT_LEN - 1)) begin
                    scl_f   <= scl_s2;
                    scl_cnt <= '0;
                end else begin
                    scl_cnt <= scl_cnt + 1'b1;
                end
            end else begin
                scl_cnt <= '0;
            end
            if (sda_s2 != sda_f) begin
                if (sda_cnt == FW'(FILT_LEN - 1)) begin
                    sda_f   <= sda_s2;
                    sda_cnt <= '0;
                end else begin
                    sda_cnt <= sda_cnt + 1'b1;
                end
            end else begin
                sda_cnt <= '0;
            end
            scl_fd <= scl_f;
            sda_fd <= sda_f;
        end
    end

    // Bus event decode from the filtered lines
    always_comb begin
        scl_rise  = scl_f & ~scl_fd;
        scl_fall  = ~scl_f & scl_fd;
        start_det = scl_f & scl_fd & sda_fd & ~sda_f;
        stop_det  = scl_f & scl_fd & ~sda_fd & sda_f;
        hold_done = (hold_cnt == HW'(1));
        byte_in   = {shreg[6:0], sda_f};
        ptr_nxt   = ptr + 1'b1;
    end

    // SDA hold timer: restarts on every filtered SCL fall
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (scl_fall) begin
            hold_cnt <= HW'(HOLD_CYC);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Protocol FSM, register file and registered bus-side outputs
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bus.sda_oe  <= 1'b0;
            busy        <= 1'b0;
            wr_evt      <= 1'b0;
            wr_evt_addr <= '0;
            wr_evt_data <= '0;
            ptr         <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            nine        <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_evt <= 1'b0;
            if (stop_det) begin
                state      <= IDLE;
                bus.sda_oe <= 1'b0;
                busy       <= 1'b0;
                bit_cnt    <= '0;
                nine       <= 1'b0;
            end else if (start_det) begin
                state      <= ADDR;
                bus.sda_oe <= 1'b0;
                bit_cnt    <= '0;
                nine       <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                nine    <= 1'b0;
                                case (state)
                                    ADDR: begin
                                        if (byte_in[7:1] == DEV_ADDR) begin
                                            state <= ADDR_ACK;
                                            busy  <= 1'b1;
                                        end else begin
                                            state <= IGNORE;
                                            busy  <= 1'b0;
                                        end
                                    end
                                    PTR: begin
                                        ptr   <= byte_in[REG_AW-1:0];
                                        state <= PTR_ACK;
                                    end
                                    default: begin
                                        regs[ptr]   <= byte_in;
                                        wr_evt      <= 1'b1;
                                        wr_evt_addr <= ptr;
                                        wr_evt_data <= byte_in;
                                        ptr         <= ptr_nxt;
                                        state       <= WACK;
                                    end
                                endcase
                            end
                        end
                    end
                    // ACK phases: first hold expiry (after 8th fall) pulls SDA,
                    // the one after the 9th fall releases and moves on
                    ADDR_ACK, PTR_ACK, WACK: begin
                        if (scl_rise) begin
                            nine <= 1'b1;
                        end
                        if (hold_done) begin
                            if (!nine) begin
                                bus.sda_oe <= 1'b1;
                            end else begin
                                nine    <= 1'b0;
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && shreg[0]) begin
                                    state      <= RDATA;
                                    shreg      <= regs[ptr];
                                    bus.sda_oe <= ~regs[ptr][7];
                                end else begin
                                    bus.sda_oe <= 1'b0;
                                    state      <= (state == ADDR_ACK) ? PTR : WDATA;
                                end
                            end
                        end
                    end
                    // Bit 7 is already on the bus on entry; each later hold
                    // expiry presents the next bit, the 8th releases SDA
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (hold_done) begin
                            if (bit_cnt == 4'd8) begin
                                bus.sda_oe <= 1'b0;
                                ptr        <= ptr_nxt;
                                bit_cnt    <= '0;
                                nine       <= 1'b0;
                                state      <= RACK;
                            end else begin
                                bus.sda_oe <= ~shreg[6];
                                shreg      <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state <= IGNORE;
                            end else begin
                                nine <= 1'b1;
                            end
                        end else if (hold_done && nine) begin
                            nine       <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= RDATA;
                            shreg      <= regs[ptr];
                            bus.sda_oe <= ~regs[ptr][7];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Local read port, one cycle latency; a same-cycle bus write shows next cycle
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            loc_rdata <= '0;
        end else begin
            loc_rdata <= regs[loc_addr];
        end
    end
endmodule
